// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
// calc_sequencer
//   Programmable-calculator controller. Fetches instructions from an
//   asynchronous-read instruction ROM, hands operands and mode to the ALU
//   with a start/done handshake, and writes each result into one of NUM_CH
//   transcript memories.
//
//   Instruction layout, MSB to LSB: [CH | MODE | A | B]
//     CH = 0          halt opcode
//     CH = 1..NUM_CH  execute, store into transcript channel CH-1
//     CH > NUM_CH     illegal: halt and raise the sticky error flag
//
// Ports
//   clock             system clock, rising edge
//   reset_n           asynchronous active-low reset
//   start             level; leaves IDLE or HALT
//   inst_mem_data     ROM read data at inst_addr
//   inst_addr         program counter
//   a, b, mode        ALU operands and mode
//   alu_start         one-cycle ALU launch pulse
//   alu_done          ALU result valid
//   trans_mem_full    per-channel full flag
//   trans_mem_wen     per-channel write enable (one-hot or zero)
//   trans_mem_cnt_en  per-channel address advance, same as trans_mem_wen
//   done              high while halted
//   error             sticky illegal-opcode flag
//   current_instr     debug: latched instruction
//   controller_state  debug: FSM state
//   instr_count       completed stores, saturating (only with
//                     CALC_SEQ_INSTR_COUNT_EN defined)
//
// Optional build macro: CALC_SEQ_INSTR_COUNT_EN
//
// State table
//   state   | meaning
//   IDLE    | after reset, all outputs 0, wait for start
//   FETCH   | latch instruction at inst_addr and decode its opcode
//   EXECUTE | ALU running, wait for alu_done
//   STORE   | write to transcript channel; stall while it is full
//   HALT    | program finished or illegal opcode; done=1, wait for start

module calc_sequencer #(
   parameter int DATA_W     = 8,
   parameter int MODE_W     = 4,
   parameter int NUM_CH     = 2,
   parameter int CH_W       = 2,
   parameter int INST_DEPTH = 16,
   parameter int INSTR_W    = CH_W + MODE_W + 2*DATA_W,
   localparam int AW        = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [INSTR_W-1:0] inst_mem_data,
   output logic [AW-1:0]      inst_addr,
   output logic [DATA_W-1:0]  a,
   output logic [DATA_W-1:0]  b,
   output logic [MODE_W-1:0]  mode,
   output logic               alu_start,
   input  logic               alu_done,
   input  logic [NUM_CH-1:0]  trans_mem_full,
   output logic [NUM_CH-1:0]  trans_mem_wen,
   output logic [NUM_CH-1:0]  trans_mem_cnt_en,
   output logic               done,
   output logic               error,
   output logic [INSTR_W-1:0] current_instr,
   output logic [2:0]         controller_state
`ifdef CALC_SEQ_INSTR_COUNT_EN
   ,
   output logic [15:0]        instr_count
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_EXECUTE = 3'd2;
   localparam logic [2:0] S_STORE   = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   logic [2:0]        state;
   logic [CH_W-1:0]   fetch_ch;
   logic [CH_W-1:0]   cur_ch;
   logic [MODE_W-1:0] fetch_mode;
   logic [DATA_W-1:0] fetch_a;
   logic [DATA_W-1:0] fetch_b;
   logic              fetch_illegal;
   logic              last_addr;
   logic [NUM_CH-1:0] ch_sel;
   logic              ch_full;

   assign fetch_ch      = inst_mem_data[INSTR_W-1 -: CH_W];
   assign fetch_mode    = inst_mem_data[2*DATA_W +: MODE_W];
   assign fetch_a       = inst_mem_data[DATA_W +: DATA_W];
   assign fetch_b       = inst_mem_data[0 +: DATA_W];
   assign fetch_illegal = (fetch_ch > CH_W'(NUM_CH));
   assign cur_ch        = current_instr[INSTR_W-1 -: CH_W];
   assign last_addr     = (inst_addr == AW'(INST_DEPTH-1));

   // Channel select from the latched instruction; only meaningful in
   // EXECUTE/STORE where the opcode is known to be legal.
   always_comb begin
      ch_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cur_ch == CH_W'(i+1)) ch_sel[i] = 1'b1;
      end
   end

   assign ch_full = |(trans_mem_full & ch_sel);

   assign controller_state = state;
   assign trans_mem_cnt_en = trans_mem_wen;

   // The write strobe is registered, so it is scheduled one edge ahead:
   // a STORE cycle with the strobe up is the write cycle and leaves STORE,
   // a STORE cycle without it is a stall that re-checks the full flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         inst_addr     <= '0;
         a             <= '0;
         b             <= '0;
         mode          <= '0;
         alu_start     <= 1'b0;
         trans_mem_wen <= '0;
         done          <= 1'b0;
         error         <= 1'b0;
         current_instr <= '0;
      end else begin
         alu_start     <= 1'b0;
         trans_mem_wen <= '0;
         case (state)
            S_IDLE: begin
               if (start) state <= S_FETCH;
            end
            S_FETCH: begin
               current_instr <= inst_mem_data;
               if (fetch_ch == '0 || fetch_illegal) begin
                  state <= S_HALT;
                  done  <= 1'b1;
                  a     <= '0;
                  b     <= '0;
                  mode  <= '0;
                  if (fetch_illegal) error <= 1'b1;
               end else begin
                  state     <= S_EXECUTE;
                  a         <= fetch_a;
                  b         <= fetch_b;
                  mode      <= fetch_mode;
                  alu_start <= 1'b1;
               end
            end
            S_EXECUTE: begin
               if (alu_done) begin
                  state <= S_STORE;
                  if (!ch_full) trans_mem_wen <= ch_sel;
               end
            end
            S_STORE: begin
               if (|trans_mem_wen) begin
                  if (last_addr) begin
                     state <= S_HALT;
                     done  <= 1'b1;
                     a     <= '0;
                     b     <= '0;
                     mode  <= '0;
                  end else begin
                     state     <= S_FETCH;
                     inst_addr <= inst_addr + 1'b1;
                  end
               end else if (!ch_full) begin
                  trans_mem_wen <= ch_sel;
               end
            end
            S_HALT: begin
               if (start) begin
                  state     <= S_FETCH;
                  inst_addr <= '0;
                  error     <= 1'b0;
                  done      <= 1'b0;
               end
            end
            default: begin
               state         <= S_IDLE;
               inst_addr     <= '0;
               a             <= '0;
               b             <= '0;
               mode          <= '0;
               done          <= 1'b0;
               error         <= 1'b0;
               current_instr <= '0;
            end
         endcase
      end
   end

`ifdef CALC_SEQ_INSTR_COUNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_count <= '0;
      end else if (state == S_HALT && start) begin
         instr_count <= '0;
      end else if (|trans_mem_wen && instr_count != 16'hFFFF) begin
         instr_count <= instr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
module tb_calc_sequencer;

   localparam int DEPTH = 16;
   localparam int IW    = 22;
   localparam int NCH   = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset_n = 1'b0;
   logic          start   = 1'b0;
   logic          alu_done = 1'b0;
   logic [IW-1:0] inst_mem_data;
   logic [3:0]    inst_addr;
   logic [7:0]    a, b;
   logic [3:0]    mode;
   logic          alu_start;
   logic [1:0]    trans_mem_full, trans_mem_wen, trans_mem_cnt_en;
   logic          done, error;
   logic [IW-1:0] current_instr;
   logic [2:0]    controller_state;
`ifdef CALC_SEQ_INSTR_COUNT_EN
   logic [15:0]   instr_count;
`endif

   logic [IW-1:0] rom [DEPTH];
   assign inst_mem_data = rom[inst_addr];

   logic [1:0] full_force = 2'b00;
   logic [1:0] full_rand_val = 2'b00;
   bit         full_rand_en = 1'b0;
   assign trans_mem_full = full_rand_en ? full_rand_val : full_force;

   calc_sequencer dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .inst_mem_data(inst_mem_data), .inst_addr(inst_addr),
      .a(a), .b(b), .mode(mode), .alu_start(alu_start), .alu_done(alu_done),
      .trans_mem_full(trans_mem_full), .trans_mem_wen(trans_mem_wen),
      .trans_mem_cnt_en(trans_mem_cnt_en), .done(done), .error(error),
      .current_instr(current_instr), .controller_state(controller_state)
`ifdef CALC_SEQ_INSTR_COUNT_EN
      , .instr_count(instr_count)
`endif
   );

   // Second instance: 4-entry program, ALU answers in the launch cycle.
   logic          start4 = 1'b0;
   logic [IW-1:0] rom4 [4];
   logic [IW-1:0] inst_mem_data4;
   logic [1:0]    inst_addr4;
   logic [7:0]    a4, b4;
   logic [3:0]    mode4;
   logic          alu_start4;
   logic [1:0]    wen4, cnt_en4;
   logic          done4, error4;
   logic [IW-1:0] cur4;
   logic [2:0]    state4;
`ifdef CALC_SEQ_INSTR_COUNT_EN
   logic [15:0]   count4;
`endif
   assign inst_mem_data4 = rom4[inst_addr4];

   calc_sequencer #(.INST_DEPTH(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .start(start4),
      .inst_mem_data(inst_mem_data4), .inst_addr(inst_addr4),
      .a(a4), .b(b4), .mode(mode4), .alu_start(alu_start4), .alu_done(alu_start4),
      .trans_mem_full(2'b00), .trans_mem_wen(wen4),
      .trans_mem_cnt_en(cnt_en4), .done(done4), .error(error4),
      .current_instr(cur4), .controller_state(state4)
`ifdef CALC_SEQ_INSTR_COUNT_EN
      , .instr_count(count4)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ALU model: done after a random latency in [lat_min, lat_max] cycles
   // counted from the launch cycle (0 = same cycle as alu_start).
   int lat_min = 1, lat_max = 1;
   int lat_cnt = -1;
   always @(negedge clock) begin
      alu_done = 1'b0;
      if (alu_start === 1'b1) lat_cnt = int'($urandom_range(lat_max, lat_min));
      if (lat_cnt == 0) alu_done = 1'b1;
      if (lat_cnt >= 0) lat_cnt--;
   end

   always @(negedge clock) full_rand_val = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;

   // Observation log of ALU launches and transcript writes.
   logic [19:0] obs_op [$];
   logic [1:0]  obs_wen [$];
   int          wcount4 = 0;
   always @(negedge clock) begin
      if (alu_start === 1'b1) obs_op.push_back({mode, a, b});
      if (trans_mem_wen !== 2'b00 || trans_mem_cnt_en !== 2'b00) begin
         obs_wen.push_back(trans_mem_wen);
         chk("cnt_en_eq_wen", 32'(trans_mem_cnt_en), 32'(trans_mem_wen));
      end
      if (wen4 !== 2'b00) wcount4++;
   end

   function automatic logic [IW-1:0] mk(int ch, int md, int av, int bv);
      return {2'(ch), 4'(md), 8'(av), 8'(bv)};
   endfunction

   task automatic pulse_start();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk("halt_reached", 32'(done), 32'd1);
   endtask

   // Reference model walks the ROM by the opcode rules and predicts the
   // ALU launches, the channel writes, the final PC and the error flag.
   task automatic run_program(input string tag, input bit check_cycles, input int exp_cycles);
      logic [19:0] e_op [$];
      logic [1:0]  e_wen [$];
      int fa = 0, n, ch, base_op, base_wen;
      bit fe = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ch = int'(rom[i][IW-1 -: 2]);
         fa = i;
         if (ch == 0) break;
         if (ch > NCH) begin fe = 1'b1; break; end
         e_op.push_back(rom[i][19:0]);
         e_wen.push_back(2'(1 << (ch - 1)));
      end
      base_op  = obs_op.size();
      base_wen = obs_wen.size();
      pulse_start();
      chk({tag, "_start_state"}, 32'(controller_state), 32'd1);
      chk({tag, "_start_addr"},  32'(inst_addr), 32'd0);
      chk({tag, "_start_flags"}, {30'd0, done, error}, 32'd0);
`ifdef CALC_SEQ_INSTR_COUNT_EN
      chk({tag, "_start_count"}, 32'(instr_count), 32'd0);
`endif
      wait_done(4000, n);
      if (check_cycles) chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
      chk({tag, "_n_alu"}, 32'(obs_op.size() - base_op), 32'(e_op.size()));
      for (int k = 0; k < e_op.size() && base_op + k < obs_op.size(); k++)
         chk($sformatf("%s_op%0d", tag, k), 32'(obs_op[base_op + k]), 32'(e_op[k]));
      chk({tag, "_n_wen"}, 32'(obs_wen.size() - base_wen), 32'(e_wen.size()));
      for (int k = 0; k < e_wen.size() && base_wen + k < obs_wen.size(); k++)
         chk($sformatf("%s_wen%0d", tag, k), 32'(obs_wen[base_wen + k]), 32'(e_wen[k]));
      chk({tag, "_state"}, 32'(controller_state), 32'd4);
      chk({tag, "_addr"},  32'(inst_addr), 32'(fa));
      chk({tag, "_error"}, 32'(error), 32'(fe));
      chk({tag, "_halt_outs"}, {8'd0, a, b, mode, alu_start, trans_mem_wen, 1'b0}, 32'd0);
`ifdef CALC_SEQ_INSTR_COUNT_EN
      chk({tag, "_count"}, 32'(instr_count), 32'(e_op.size()));
`endif
   endtask

   initial begin
      int n, base;
      for (int i = 0; i < DEPTH; i++) rom[i] = '0;
      for (int i = 0; i < 4; i++) rom4[i] = mk(1, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));

      // Reset state and IDLE holding without start.
      #12;
      chk("rst_state", 32'(controller_state), 32'd0);
      chk("rst_outs", {inst_addr, a, b, mode, alu_start, trans_mem_wen, done, error}, 32'd0);
      chk("rst_instr", 32'(current_instr), 32'd0);
      @(negedge clock) reset_n = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle_wait", 32'(controller_state), 32'd0);

      // Default program, ALU answers one cycle after the launch.
      rom[0] = mk(1, 3, 8'h12, 8'h34);
      rom[1] = mk(2, 1, 8'h05, 8'h07);
      rom[2] = mk(0, 0, 0, 0);
      run_program("dflt", 1'b1, 9);

      // Same program with same-cycle alu_done: 3 cycles per instruction.
      lat_min = 0; lat_max = 0;
      run_program("fast", 1'b1, 7);

      // Illegal opcode halts straight from FETCH.
      rom[0] = mk(3, 2, 8'hAA, 8'h55);
      run_program("illegal", 1'b1, 1);

      // Restart after an error clears it; channel 0 full stalls STORE.
      rom[0] = mk(1, 5, 8'h21, 8'h43);
      rom[1] = mk(0, 0, 0, 0);
      full_force = 2'b01;
      base = obs_wen.size();
      pulse_start();
      chk("restart_error", 32'(error), 32'd0);
      n = 0;
      while (controller_state !== 3'd3 && n < 50) begin @(negedge clock); n++; end
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall_state%0d", k), 32'(controller_state), 32'd3);
         chk($sformatf("stall_wen%0d", k), 32'(trans_mem_wen), 32'd0);
         if (k < 4) @(negedge clock);
      end
      full_force = 2'b00;
      @(negedge clock);
      chk("release_state", 32'(controller_state), 32'd3);
      chk("release_wen", 32'(trans_mem_wen), 32'd1);
      wait_done(100, n);
      chk("stall_n_wen", 32'(obs_wen.size() - base), 32'd1);

      // Asynchronous reset in the middle of EXECUTE, off a clock edge.
      lat_min = 20; lat_max = 20;
      pulse_start();
      n = 0;
      while (controller_state !== 3'd2 && n < 50) begin @(negedge clock); n++; end
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(controller_state), 32'd0);
      chk("arst_outs", {inst_addr, a, b, mode, alu_start, trans_mem_wen, done, error}, 32'd0);
      chk("arst_cnt_en", 32'(trans_mem_cnt_en), 32'd0);
      chk("arst_instr", 32'(current_instr), 32'd0);
      @(negedge clock) reset_n = 1'b1;
      repeat (25) @(negedge clock);
      chk("arst_idle", 32'(controller_state), 32'd0);
      chk("arst_idle_done", 32'(done), 32'd0);

      // Randomised programs, ALU latency and full back-pressure.
      lat_min = 0; lat_max = 3;
      full_rand_en = 1'b1;
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            int ch;
            ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) * 3 : int'($urandom_range(1, 2));
            rom[i] = mk(ch, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
         end
         run_program($sformatf("rnd%0d", p), 1'b0, 0);
      end
      full_rand_en = 1'b0;

      // Four-entry program runs to the last address without wrapping.
      base = wcount4;
      @(negedge clock) start4 = 1'b1;
      @(negedge clock) start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      chk("d4_halt", 32'(done4), 32'd1);
      chk("d4_writes", 32'(wcount4 - base), 32'd4);
      chk("d4_addr", 32'(inst_addr4), 32'd3);
      chk("d4_error", 32'(error4), 32'd0);
`ifdef CALC_SEQ_INSTR_COUNT_EN
      chk("d4_count", 32'(count4), 32'd4);
`endif
      repeat (3) @(negedge clock);
      chk("d4_absorb", 32'(state4), 32'd4);
      @(negedge clock) start4 = 1'b1;
      @(negedge clock) start4 = 1'b0;
      chk("d4_restart_state", 32'(state4), 32'd1);
      chk("d4_restart_addr", 32'(inst_addr4), 32'd0);
      chk("d4_restart_flags", {30'd0, done4, error4}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
